// File: rtl/dmem_pkg.sv
// Shared types and the access-legality helper for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Alignment check only; the word-range check lives in the controller.
    function automatic logic legal(input size_e size, input logic [1:0] low_addr);
        case (size)
            SIZE_B:  legal = 1'b1;
            SIZE_H:  legal = !low_addr[0];
            SIZE_W:  legal = (low_addr == 2'b00);
            default: legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the MEM stage (master) and the data memory (slave).
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store replication plus byte enables, and load extraction with extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword[{offset, 3'b000} +: 8];
    assign half_sel = rword[{offset[1], 4'b0000} +: 16];

    // Store data is replicated across every lane so the enables alone pick the target.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        rdata_ext  = 32'h0;
        case (size)
            SIZE_B: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SIZE_W: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = 32'h0;
                rdata_ext  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory: word array behind a single-outstanding valid/ready channel
// with programmable response latency and a read-only debug probe word.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] PROBE_ADDR  = 32'h0,
    parameter logic [31:0] PROBE_VALUE = 32'hdeadbeef
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e            state;
    state_e            state_next;
    logic [2:0]        cnt;
    logic              accept;
    logic              load_resp;
    logic              in_idle;

    logic [ADDR_W-3:0] widx;
    logic              in_range;
    size_e             live_size;
    logic              live_err;
    logic              live_probe;
    logic [31:0]       mem_word;

    logic              we_q;
    logic              uns_q;
    logic              err_q;
    logic              probe_q;
    size_e             size_q;
    logic [1:0]        off_q;
    logic [31:0]       read_q;

    logic              cur_we;
    logic              cur_uns;
    logic              cur_err;
    logic              cur_probe;
    size_e             cur_size;
    logic [1:0]        cur_off;
    logic [31:0]       cur_word;

    logic [3:0]        be;
    logic [31:0]       wdata_lane;
    logic [31:0]       rdata_ext;
    logic [31:0]       rdata_r;
    logic              err_r;

    logic [31:0]       mem [DEPTH];

    assign widx       = bus.req_addr[ADDR_W-1:2];
    assign in_range   = ({2'b00, widx} < ADDR_W'(DEPTH));
    assign live_size  = size_e'(bus.req_size);
    assign live_err   = !legal(live_size, bus.req_addr[1:0]) || !in_range;
    assign live_probe = (live_size == SIZE_W) && (bus.req_addr == ADDR_W'(PROBE_ADDR));
    assign mem_word   = mem[widx[IDX_W-1:0]];
    assign in_idle    = (state == IDLE);
    assign accept     = bus.req_valid && in_idle;

    // In IDLE the live request feeds the datapath (store lanes, LATENCY==1 response);
    // afterwards the captured copy does.
    assign cur_we    = in_idle ? bus.req_we       : we_q;
    assign cur_uns   = in_idle ? bus.req_unsigned : uns_q;
    assign cur_err   = in_idle ? live_err         : err_q;
    assign cur_probe = in_idle ? live_probe       : probe_q;
    assign cur_size  = in_idle ? live_size        : size_q;
    assign cur_off   = in_idle ? bus.req_addr[1:0] : off_q;
    assign cur_word  = in_idle ? mem_word         : read_q;

    dmem_lane_align u_align (
        .size        (cur_size),
        .offset      (cur_off),
        .is_unsigned (cur_uns),
        .wdata       (bus.req_wdata),
        .rword       (cur_word),
        .be          (be),
        .wdata_lane  (wdata_lane),
        .rdata_ext   (rdata_ext)
    );

    // Array has no reset, so a store committed before a reset survives it.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !live_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx[IDX_W-1:0]][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        load_resp  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        load_resp  = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_next = RESP;
                    load_resp  = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            probe_q <= 1'b0;
            size_q  <= SIZE_W;
            off_q   <= 2'b00;
            read_q  <= 32'h0;
            rdata_r <= 32'h0;
            err_r   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt     <= (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                err_q   <= live_err;
                probe_q <= live_probe;
                size_q  <= live_size;
                off_q   <= bus.req_addr[1:0];
                if (!bus.req_we && !live_err) begin
                    read_q <= mem_word;
                end
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            // Response registers only move on entry to RESP, which keeps them stable under stall.
            if (load_resp) begin
                err_r <= cur_err;
                if (cur_we || cur_err) begin
                    rdata_r <= 32'h0;
                end else if (cur_probe) begin
                    rdata_r <= PROBE_VALUE;
                end else begin
                    rdata_r <= rdata_ext;
                end
            end
        end
    end

    assign bus.req_ready  = in_idle;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = err_r;

endmodule
